// File: rtl/sm4_block_gather.sv
// sm4_block_gather: packs 32-bit SM4 result words into 128-bit blocks
// and queues whole blocks in a small FIFO for a 128-bit consumer.
//
// Ports:
//   clk, rst           rising-edge clock, sync active-high reset
//   S_AXIS_T*          32-bit result stream from the SM4 engine
//   blk_data/last      head block (first word in [127:96]), show-ahead
//   blk_valid/ready    block handshake, blk_count = FIFO occupancy
//   err_short/strb     sticky framing flags, err_clr clears them
module sm4_block_gather #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATAWIDTH-1:0]      S_AXIS_TDATA,
  input  logic [DATAWIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic                      S_AXIS_TLAST,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  output logic [4*DATAWIDTH-1:0]    blk_data,
  output logic                      blk_last,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [$clog2(DEPTH):0]    blk_count,
  output logic                      err_short,
  output logic                      err_strb,
  input  logic                      err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = DATAWIDTH;
  localparam int BW = 4 * DATAWIDTH;

  logic [1:0]     wcnt_q, wcnt_d;
  logic [3*W-1:0] part_q, part_d;
  logic [BW:0]    mem_q [DEPTH];
  logic [BW:0]    mem_d [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           short_q, short_d;
  logic           strb_q, strb_d;

  logic accept;
  logic push;
  logic pop;
  logic set_short;
  logic set_strb;

  // Ready looks only at registered occupancy: no path from blk_ready.
  assign S_AXIS_TREADY = ~rst & (cnt_q != CW'(DEPTH));
  assign blk_valid     = (cnt_q != '0);
  assign blk_count     = cnt_q;
  assign {blk_data, blk_last} = mem_q[rptr_q];
  assign err_short     = short_q;
  assign err_strb      = strb_q;

  always_comb begin
    accept    = S_AXIS_TVALID & S_AXIS_TREADY;
    pop       = blk_valid & blk_ready;
    push      = 1'b0;
    set_short = 1'b0;
    set_strb  = accept & (S_AXIS_TSTRB != '1);
    wcnt_d    = wcnt_q;
    part_d    = part_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;

    if (accept) begin
      if (wcnt_q == 2'd3) begin
        push   = 1'b1;
        wcnt_d = 2'd0;
      end else if (S_AXIS_TLAST) begin
        // short packet: drop the partial block
        set_short = 1'b1;
        wcnt_d    = 2'd0;
      end else begin
        case (wcnt_q)
          2'd0:    part_d[3*W-1:2*W] = S_AXIS_TDATA;
          2'd1:    part_d[2*W-1:W]   = S_AXIS_TDATA;
          default: part_d[W-1:0]     = S_AXIS_TDATA;
        endcase
        wcnt_d = wcnt_q + 2'd1;
      end
    end

    if (push) begin
      mem_d[wptr_q] = {part_q, S_AXIS_TDATA, S_AXIS_TLAST};
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // a same-cycle set beats the clear
    short_d = set_short | (short_q & ~err_clr);
    strb_d  = set_strb | (strb_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q  <= '0;
      part_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      short_q <= 1'b0;
      strb_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wcnt_q  <= wcnt_d;
      part_q  <= part_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      strb_q  <= strb_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_sm4_block_gather.sv
// tb_sm4_block_gather: directed + random stimulus for sm4_block_gather
// checked every cycle against a queue-based block reference model.
module tb_sm4_block_gather;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  tdata;
  logic [3:0]   tstrb;
  logic         tlast;
  logic         tvalid;
  logic         tready;
  logic [127:0] blk_data;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [2:0]   blk_count;
  logic         err_short;
  logic         err_strb;
  logic         err_clr;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [128:0] m_fifo [$];
  logic [31:0]  m_part [$];
  bit           m_short;
  bit           m_strb;
  bit           m_zero;
  bit           last_acc;
  bit           m_acc;
  bit           m_pop;
  bit           m_sset;
  bit           m_bset;

  sm4_block_gather #(.DATAWIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .blk_data(blk_data),
    .blk_last(blk_last),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_count(blk_count),
    .err_short(err_short),
    .err_strb(err_strb),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [128:0] obs,
                     input logic [128:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Model: words gather into groups of four; a TLAST before the
  // fourth word throws the group away.
  always @(posedge clk) begin
    m_acc    = tvalid && !rst && (m_fifo.size() != DEPTH);
    m_pop    = blk_ready && (m_fifo.size() != 0);
    last_acc = 1'b0;
    if (rst) begin
      m_fifo.delete();
      m_part.delete();
      m_short = 1'b0;
      m_strb  = 1'b0;
      m_zero  = 1'b1;
    end else begin
      m_sset = 1'b0;
      m_bset = 1'b0;
      if (m_pop) void'(m_fifo.pop_front());
      if (m_acc) begin
        last_acc = 1'b1;
        if (tstrb != 4'hF) m_bset = 1'b1;
        m_part.push_back(tdata);
        if (m_part.size() == 4) begin
          m_fifo.push_back({m_part[0], m_part[1],
                            m_part[2], m_part[3], tlast});
          m_part.delete();
          m_zero = 1'b0;
        end else if (tlast) begin
          m_part.delete();
          m_sset = 1'b1;
        end
      end
      m_short = m_sset || (m_short && !err_clr);
      m_strb  = m_bset || (m_strb && !err_clr);
    end
  end

  task automatic check_all();
    chk("tready", 129'(tready),
        129'(!rst && (m_fifo.size() != DEPTH)));
    chk("valid", 129'(blk_valid), 129'(m_fifo.size() != 0));
    chk("count", 129'(blk_count), 129'(m_fifo.size()));
    chk("count_max", 129'(blk_count <= DEPTH), 129'(1));
    chk("err_short", 129'(err_short), 129'(m_short));
    chk("err_strb", 129'(err_strb), 129'(m_strb));
    if (m_fifo.size() != 0)
      chk("blk", {blk_data, blk_last}, m_fifo[0]);
    else if (m_zero)
      chk("blk_rst", {blk_data, blk_last}, 129'(0));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask

  task automatic drain(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [31:0] d,
                      input logic l,
                      input logic [3:0] s);
    int n;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    tstrb  = s;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) chk("accept_timeout", 129'(0), 129'(1));
    tvalid = 1'b0;
  endtask

  task automatic send_blk(input int bad);
    for (int i = 0; i < 4; i++)
      send($urandom, i == 3, (i == bad) ? 4'h7 : 4'hF);
  endtask

  initial begin
    logic [31:0] w17;
    rst = 1'b1;
    tdata = '0;
    tstrb = 4'hF;
    tlast = 1'b0;
    tvalid = 1'b0;
    blk_ready = 1'b0;
    err_clr = 1'b0;
    drain(2);
    rst = 1'b0;
    drain(1);

    // single block, one-cycle latency
    blk_ready = 1'b1;
    send(32'h01234567, 1'b0, 4'hF);
    send(32'h89ABCDEF, 1'b0, 4'hF);
    send(32'hFEDCBA98, 1'b0, 4'hF);
    send(32'h76543210, 1'b1, 4'hF);
    chk("t1_valid", 129'(blk_valid), 129'(1));
    chk("t1_data", 129'(blk_data),
        129'(128'h0123456789ABCDEFFEDCBA9876543210));
    chk("t1_last", 129'(blk_last), 129'(1));
    drain(2);

    // backpressure: fill, stall the 17th word, then drain with wrap
    blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send($urandom, (i % 4) == 3, 4'hF);
    chk("t2_count", 129'(blk_count), 129'(DEPTH));
    w17 = $urandom;
    tvalid = 1'b1;
    tdata = w17;
    tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_hold", 129'(last_acc), 129'(0));
    end
    blk_ready = 1'b1;
    send(w17, 1'b0, 4'hF);
    for (int i = 1; i < 4; i++) send($urandom, i == 3, 4'hF);
    drain(8);
    chk("t2_empty", 129'(blk_count), 129'(0));

    // short block then a good one
    send($urandom, 1'b0, 4'hF);
    send($urandom, 1'b1, 4'hF);
    chk("t3_short", 129'(err_short), 129'(1));
    send_blk(-1);
    drain(3);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t3_clr", 129'(err_short), 129'(0));

    // strobe error, then clear; then set and clear together
    send_blk(2);
    chk("t4_strb", 129'(err_strb), 129'(1));
    drain(2);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t4_clr_s", 129'(err_strb), 129'(0));
    chk("t4_clr_h", 129'(err_short), 129'(0));
    err_clr = 1'b1;
    send($urandom, 1'b0, 4'h3);
    err_clr = 1'b0;
    chk("t4_set_wins", 129'(err_strb), 129'(1));
    for (int i = 1; i < 4; i++) send($urandom, i == 3, 4'hF);
    drain(3);

    // full FIFO with continuous pops and streaming
    blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send($urandom, (i % 4) == 3, 4'hF);
    blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) send($urandom, (i % 4) == 3, 4'hF);
    drain(8);

    // mid-block reset
    for (int i = 0; i < 3; i++) send($urandom, 1'b0, 4'hF);
    rst = 1'b1;
    cyc();
    chk("t6_rst_tready", 129'(tready), 129'(0));
    chk("t6_rst_data", 129'(blk_data), 129'(0));
    rst = 1'b0;
    send_blk(-1);
    drain(3);
    chk("t6_one_blk", 129'(blk_count), 129'(0));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tvalid    = ($urandom % 4) != 0;
      tdata     = $urandom;
      tlast     = ($urandom % 5) == 0;
      tstrb     = (($urandom % 16) == 0) ? 4'($urandom) : 4'hF;
      blk_ready = ($urandom % 3) != 0;
      err_clr   = ($urandom % 20) == 0;
      rst       = ($urandom % 500) == 0;
      cyc();
    end
    tvalid = 1'b0;
    rst = 1'b0;
    err_clr = 1'b0;
    blk_ready = 1'b1;
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
